// File: rtl/dmi_req_arbiter_if.sv
// dmi_req_arbiter_if: handshake bundle around the DMI request arbiter.
//   r0_* / r1_* : requester request channels (valid/ready/bits) and their
//                 response channels (valid/ready/bits).
//   dm_*        : single request/response channel toward the debug module.
// Modports:
//   slave  - the arbiter's view (accepts requests, issues DM traffic).
//   master - the surrounding environment (requesters plus DM side).
// REQ_W/RESP_W must match the arbiter's derived {addr,data,op} / {data,resp}.
interface dmi_req_arbiter_if #(
  parameter int REQ_W  = 41,
  parameter int RESP_W = 36
);
  logic              r0_req_valid, r0_req_ready;
  logic [REQ_W-1:0]  r0_req_bits;
  logic              r0_resp_valid, r0_resp_ready;
  logic [RESP_W-1:0] r0_resp_bits;
  logic              r1_req_valid, r1_req_ready;
  logic [REQ_W-1:0]  r1_req_bits;
  logic              r1_resp_valid, r1_resp_ready;
  logic [RESP_W-1:0] r1_resp_bits;
  logic              dm_req_valid, dm_req_ready;
  logic [REQ_W-1:0]  dm_req_bits;
  logic              dm_resp_valid, dm_resp_ready;
  logic [RESP_W-1:0] dm_resp_bits;

  modport slave (
    input  r0_req_valid, r0_req_bits, r0_resp_ready,
    input  r1_req_valid, r1_req_bits, r1_resp_ready,
    input  dm_req_ready, dm_resp_valid, dm_resp_bits,
    output r0_req_ready, r0_resp_valid, r0_resp_bits,
    output r1_req_ready, r1_resp_valid, r1_resp_bits,
    output dm_req_valid, dm_req_bits, dm_resp_ready
  );

  modport master (
    output r0_req_valid, r0_req_bits, r0_resp_ready,
    output r1_req_valid, r1_req_bits, r1_resp_ready,
    output dm_req_ready, dm_resp_valid, dm_resp_bits,
    input  r0_req_ready, r0_resp_valid, r0_resp_bits,
    input  r1_req_ready, r1_resp_valid, r1_resp_bits,
    input  dm_req_valid, dm_req_bits, dm_resp_ready
  );
endinterface

// File: rtl/dmi_req_arbiter.sv
// dmi_req_arbiter: shares one DMI port between two TCK-domain requesters.
// Round-robin grant, one transaction outstanding, response routed back to
// its owner, optional timeout that synthesises a failed response.
// Ports:
//   clk           - TCK-domain clock, rising edge
//   jtag_TRST     - asynchronous active-high reset
//   bus           - dmi_req_arbiter_if.slave (requester + DM channels)
//   grant_id      - owner of the current/last transaction
//   busy          - state not IDLE, or a late DM response is still owed
//   timeout_pulse - one-cycle pulse when the timeout fires
module dmi_req_arbiter #(
  parameter int DEBUG_DATA_BITS = 34,
  parameter int DEBUG_ADDR_BITS = 5,
  parameter int DEBUG_OP_BITS   = 2,
  parameter int TIMEOUT_CYCLES  = 1023,
  parameter int TIMEOUT_W       = 10
) (
  input  logic            clk,
  input  logic            jtag_TRST,
  dmi_req_arbiter_if.slave bus,
  output logic            grant_id,
  output logic            busy,
  output logic            timeout_pulse
);
  localparam int REQ_W  = DEBUG_OP_BITS + DEBUG_ADDR_BITS + DEBUG_DATA_BITS;
  localparam int RESP_W = DEBUG_OP_BITS + DEBUG_DATA_BITS;
  localparam bit                   TO_EN  = (TIMEOUT_CYCLES != 0);
  localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_CYCLES);
  // Synthetic failure: zero data, resp = 2'b10 (failed).
  localparam logic [RESP_W-1:0]    TO_RESP = {{DEBUG_DATA_BITS{1'b0}}, DEBUG_OP_BITS'(2)};

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t               state;
  logic                 ptr;    // preferred requester when both are valid
  logic                 stale;  // a timed-out DM response is still in flight
  logic [REQ_W-1:0]     req_buf;
  logic [RESP_W-1:0]    resp_buf;
  logic [TIMEOUT_W-1:0] to_cnt;

  logic [1:0]            req_vld, req_rdy, resp_rdy;
  logic [1:0][REQ_W-1:0] req_bits;
  logic                  win, grant_ok;

  assign req_vld  = {bus.r1_req_valid, bus.r0_req_valid};
  assign req_bits = {bus.r1_req_bits, bus.r0_req_bits};
  assign resp_rdy = {bus.r1_resp_ready, bus.r0_resp_ready};

  // Winner: the lone valid requester, or ptr on a tie. When nobody is
  // valid the value is irrelevant because grant_ok is low.
  always_comb begin
    win      = (&req_vld) ? ptr : req_vld[1];
    grant_ok = (state == IDLE) && !stale && (|req_vld) && !jtag_TRST;
    req_rdy  = '0;
    req_rdy[win] = grant_ok;
  end

  assign bus.r0_req_ready  = req_rdy[0];
  assign bus.r1_req_ready  = req_rdy[1];
  assign bus.dm_req_valid  = (state == REQ);
  assign bus.dm_req_bits   = req_buf;
  // While stale, keep draining so the orphaned response cannot wedge the DM.
  assign bus.dm_resp_ready = (state == WAIT) || stale;
  assign bus.r0_resp_valid = (state == RESP) && !grant_id;
  assign bus.r1_resp_valid = (state == RESP) &&  grant_id;
  assign bus.r0_resp_bits  = resp_buf;
  assign bus.r1_resp_bits  = resp_buf;
  assign busy              = (state != IDLE) || stale;

  always_ff @(posedge clk or posedge jtag_TRST) begin
    if (jtag_TRST) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      stale         <= 1'b0;
      req_buf       <= '0;
      resp_buf      <= '0;
      to_cnt        <= '0;
      grant_id      <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      // Stale is only ever set outside WAIT use, so this drain never
      // competes with a real capture below.
      if (stale && bus.dm_resp_valid) stale <= 1'b0;
      case (state)
        IDLE: if (grant_ok) begin
          req_buf  <= req_bits[win];
          grant_id <= win;
          ptr      <= ~win;
          state    <= REQ;
        end
        REQ: if (bus.dm_req_ready) begin
          to_cnt <= '0;
          state  <= WAIT;
        end
        WAIT: begin
          // A real response in the expiry cycle beats the timeout.
          if (bus.dm_resp_valid) begin
            resp_buf <= bus.dm_resp_bits;
            state    <= RESP;
          end else if (TO_EN && to_cnt == TO_LIM) begin
            resp_buf      <= TO_RESP;
            stale         <= 1'b1;
            timeout_pulse <= 1'b1;
            state         <= RESP;
          end else if (to_cnt != '1) begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        RESP: if (resp_rdy[grant_id]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Bench for dmi_req_arbiter: directed steps plus randomised transactions,
// checked against a round-robin reference model of the grant rules.
module tb_dmi_req_arbiter;
  localparam int DB = 34, AB = 5, OB = 2, TO = 8, TW = 4;
  localparam int REQ_W = OB + AB + DB, RESP_W = OB + DB;

  logic clk = 1'b0;
  logic jtag_TRST;
  logic grant_id, busy, timeout_pulse;
  int   n_asrt = 0, n_fail = 0;
  int   mptr = 0;   // model: preferred requester on a tie

  dmi_req_arbiter_if #(.REQ_W(REQ_W), .RESP_W(RESP_W)) bus ();

  dmi_req_arbiter #(
    .DEBUG_DATA_BITS(DB), .DEBUG_ADDR_BITS(AB), .DEBUG_OP_BITS(OB),
    .TIMEOUT_CYCLES(TO), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .jtag_TRST(jtag_TRST), .bus(bus),
    .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int pick(input bit v0, input bit v1);
    if (v0 && v1) return mptr;
    return v1 ? 1 : 0;
  endfunction

  function automatic logic [REQ_W-1:0] rnd_req();
    return REQ_W'({$urandom, $urandom});
  endfunction

  function automatic logic [RESP_W-1:0] rnd_resp();
    return RESP_W'({$urandom, $urandom});
  endfunction

  task automatic idle_inputs();
    bus.r0_req_valid = 0; bus.r1_req_valid = 0;
    bus.r0_resp_ready = 0; bus.r1_resp_ready = 0;
    bus.dm_req_ready = 0; bus.dm_resp_valid = 0;
  endtask

  // Full transaction; stall = cycles of dm_req_ready low, dly = WAIT cycles
  // before the DM answers, rdly = cycles before the owner takes the response.
  task automatic txn(input bit v0, input bit v1,
                     input logic [REQ_W-1:0] b0, input logic [REQ_W-1:0] b1,
                     input int stall, input int dly, input int rdly,
                     input logic [RESP_W-1:0] dr, output int w);
    logic [REQ_W-1:0] wb;
    w  = pick(v0, v1);
    wb = (w == 1) ? b1 : b0;
    bus.r0_req_valid = v0; bus.r0_req_bits = b0;
    bus.r1_req_valid = v1; bus.r1_req_bits = b1;
    bus.dm_req_ready = (stall == 0);
    #1;
    chk("r0_req_ready", bus.r0_req_ready, w == 0);
    chk("r1_req_ready", bus.r1_req_ready, w == 1);
    tick();
    mptr = 1 - w;
    chk("grant_id", grant_id, w);
    chk("dm_req_valid", bus.dm_req_valid, 1);
    chk("dm_req_bits", bus.dm_req_bits, wb);
    for (int i = 0; i < stall; i++) begin
      chk("stall_no_grant", bus.r0_req_ready | bus.r1_req_ready, 0);
      chk("stall_busy", busy, 1);
      tick();
      chk("stall_bits", bus.dm_req_bits, wb);
      chk("stall_valid", bus.dm_req_valid, 1);
      if (i == stall - 1) bus.dm_req_ready = 1;
    end
    tick();
    bus.dm_req_ready = 0;
    chk("wait_resp_ready", bus.dm_resp_ready, 1);
    chk("wait_req_valid", bus.dm_req_valid, 0);
    for (int i = 0; i < dly; i++) begin
      tick();
      chk("wait_no_resp", bus.r0_resp_valid | bus.r1_resp_valid, 0);
    end
    bus.dm_resp_valid = 1; bus.dm_resp_bits = dr;
    tick();
    bus.dm_resp_valid = 0;
    chk("owner_resp_valid", (w == 1) ? bus.r1_resp_valid : bus.r0_resp_valid, 1);
    chk("owner_resp_bits", (w == 1) ? bus.r1_resp_bits : bus.r0_resp_bits, dr);
    chk("other_resp_valid", (w == 1) ? bus.r0_resp_valid : bus.r1_resp_valid, 0);
    chk("no_pulse", timeout_pulse, 0);
    // Non-owner ready must not complete the transaction.
    if (w == 1) begin bus.r0_resp_ready = 1; bus.r1_resp_ready = (rdly == 0); end
    else        begin bus.r1_resp_ready = 1; bus.r0_resp_ready = (rdly == 0); end
    for (int i = 0; i < rdly; i++) begin
      tick();
      chk("resp_hold", (w == 1) ? bus.r1_resp_valid : bus.r0_resp_valid, 1);
      if (i == rdly - 1) begin
        if (w == 1) bus.r1_resp_ready = 1; else bus.r0_resp_ready = 1;
      end
    end
    tick();
    idle_inputs();
    chk("idle_busy", busy, 0);
    chk("idle_resp_valid", bus.r0_resp_valid | bus.r1_resp_valid, 0);
  endtask

  // Transaction where the DM stays silent; with exact=1 the DM answers in
  // the very cycle the counter expires.
  task automatic to_txn(input bit v0, input bit v1, input logic [REQ_W-1:0] b,
                        input bit exact, input logic [RESP_W-1:0] dr);
    int w; int pulses; logic [RESP_W-1:0] expr;
    pulses = 0;
    w = pick(v0, v1);
    bus.r0_req_valid = v0; bus.r1_req_valid = v1;
    bus.r0_req_bits = b; bus.r1_req_bits = b;
    bus.dm_req_ready = 1;
    tick();
    mptr = 1 - w;
    chk("to_grant", grant_id, w);
    tick();                       // first WAIT cycle
    bus.dm_req_ready = 0;
    for (int k = 0; k < TO; k++) begin
      pulses += int'(timeout_pulse);
      chk("to_wait_no_resp", bus.r0_resp_valid | bus.r1_resp_valid, 0);
      tick();
    end
    chk("to_edge_no_resp", bus.r0_resp_valid | bus.r1_resp_valid, 0);
    pulses += int'(timeout_pulse);
    if (exact) begin bus.dm_resp_valid = 1; bus.dm_resp_bits = dr; end
    tick();
    bus.dm_resp_valid = 0;
    expr = exact ? dr : RESP_W'(2);
    chk("to_pulse_now", timeout_pulse, !exact);
    chk("to_owner_valid", (w == 1) ? bus.r1_resp_valid : bus.r0_resp_valid, 1);
    chk("to_owner_bits", (w == 1) ? bus.r1_resp_bits : bus.r0_resp_bits, expr);
    chk("to_other_valid", (w == 1) ? bus.r0_resp_valid : bus.r1_resp_valid, 0);
    pulses += int'(timeout_pulse);
    if (w == 1) bus.r1_resp_ready = 1; else bus.r0_resp_ready = 1;
    tick();
    idle_inputs();
    pulses += int'(timeout_pulse);
    chk("to_pulse_count", pulses, exact ? 0 : 1);
    chk("to_busy_stale", busy, !exact);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int exp_order [4];
    exp_order = '{0, 1, 0, 1};
    jtag_TRST = 1;
    idle_inputs();
    bus.r0_req_bits = '0; bus.r1_req_bits = '0; bus.dm_resp_bits = '0;
    bus.r0_req_valid = 1; bus.r1_req_valid = 1;
    #12;
    chk("rst_req_ready", bus.r0_req_ready | bus.r1_req_ready, 0);
    chk("rst_dm_req_valid", bus.dm_req_valid, 0);
    chk("rst_dm_resp_ready", bus.dm_resp_ready, 0);
    chk("rst_resp_valid", bus.r0_resp_valid | bus.r1_resp_valid, 0);
    chk("rst_grant_busy_pulse", {grant_id, busy, timeout_pulse}, 0);
    bus.r0_req_valid = 0; bus.r1_req_valid = 0;
    @(posedge clk); #3;
    jtag_TRST = 0;

    // r0 reads addr 0x11; DM returns data 0x3_0000_0001, resp 0.
    txn(1, 0, REQ_W'({5'h11, 34'h0, 2'd1}), '0, 0, 0, 0, {34'h3_0000_0001, 2'b00}, w);
    chk("first_owner", w, 0);

    // r1 alone leaves ptr at r0, then a tie sequence must alternate.
    txn(0, 1, '0, rnd_req(), 0, 0, 0, rnd_resp(), w);
    for (int i = 0; i < 4; i++) begin
      txn(1, 1, rnd_req(), rnd_req(), 0, 0, 0, rnd_resp(), w);
      chk("rr_order", w, exp_order[i]);
    end

    // DM holds off the request for 7 cycles.
    txn(1, 1, rnd_req(), rnd_req(), 7, 0, 0, rnd_resp(), w);

    // Random mix of requesters, stalls and delays.
    for (int i = 0; i < 12; i++) begin
      int vv;
      vv = $urandom_range(1, 3);
      txn(vv[0], vv[1], rnd_req(), rnd_req(), $urandom_range(0, 2),
          $urandom_range(0, 3), $urandom_range(0, 2), rnd_resp(), w);
    end

    // Timeout, then a late DM response that must be swallowed.
    to_txn(0, 1, rnd_req(), 0, '0);
    bus.r0_req_valid = 1; bus.r1_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stale_no_grant", bus.r0_req_ready | bus.r1_req_ready, 0);
      chk("stale_drain_ready", bus.dm_resp_ready, 1);
      chk("stale_busy", busy, 1);
      tick();
    end
    bus.dm_resp_valid = 1; bus.dm_resp_bits = rnd_resp();
    #1;
    chk("late_no_grant", bus.r0_req_ready | bus.r1_req_ready, 0);
    tick();
    bus.dm_resp_valid = 0;
    chk("late_not_forwarded", bus.r0_resp_valid | bus.r1_resp_valid, 0);
    chk("late_cleared_busy", busy, 0);
    txn(1, 1, rnd_req(), rnd_req(), 0, 1, 0, rnd_resp(), w);

    // DM answers in the exact expiry cycle.
    to_txn(1, 0, rnd_req(), 1, rnd_resp());

    // Reset while r1 is waiting in WAIT.
    bus.r0_req_valid = 0; bus.r1_req_valid = 1; bus.r1_req_bits = rnd_req();
    bus.dm_req_ready = 1;
    tick();
    chk("pre_rst_grant", grant_id, 1);
    tick();
    bus.dm_req_ready = 0;
    chk("pre_rst_wait", bus.dm_resp_ready, 1);
    bus.r0_req_valid = 1;
    #2 jtag_TRST = 1;
    mptr = 0;
    #1;
    chk("mid_rst_req_ready", bus.r0_req_ready | bus.r1_req_ready, 0);
    chk("mid_rst_dm", {bus.dm_req_valid, bus.dm_resp_ready}, 0);
    chk("mid_rst_resp_valid", bus.r0_resp_valid | bus.r1_resp_valid, 0);
    chk("mid_rst_grant_busy_pulse", {grant_id, busy, timeout_pulse}, 0);
    @(posedge clk); #3;
    jtag_TRST = 0;
    idle_inputs();
    txn(0, 1, '0, rnd_req(), 0, 0, 0, rnd_resp(), w);
    chk("post_rst_r1", w, 1);

    // Leave ptr pointing at r1, reset in IDLE, tie must go to r0.
    txn(1, 0, rnd_req(), '0, 0, 0, 0, rnd_resp(), w);
    #2 jtag_TRST = 1;
    mptr = 0;
    @(posedge clk); #3;
    jtag_TRST = 0;
    txn(1, 1, rnd_req(), rnd_req(), 0, 0, 0, rnd_resp(), w);
    chk("post_rst_tie_r0", w, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
